// File: rtl/vvp_bitserial_acc_if.sv
// Handshake and configuration bundle for the bit-serial vector dot-product accumulator.
// The master side feeds bit-planes and consumes the result; the slave side is the accumulator.
interface vvp_bitserial_acc_if #(
  parameter int unsigned N    = 64,
  parameter int unsigned PMAX = 8,
  parameter int unsigned ACCW = $clog2(N + 1) + 2 * PMAX + 1
);
  localparam int unsigned CW = $clog2(PMAX + 1);

  logic            start;
  logic [CW-1:0]   cfg_wprec;
  logic [CW-1:0]   cfg_dprec;
  logic            cfg_wsigned;
  logic            cfg_dsigned;
  logic            busy;
  logic            in_valid;
  logic            in_ready;
  logic [N-1:0]    in_w;
  logic [N-1:0]    in_d;
  logic            out_valid;
  logic            out_ready;
  logic [ACCW-1:0] out_sum;

  modport master (
    output start, cfg_wprec, cfg_dprec, cfg_wsigned, cfg_dsigned,
    output in_valid, in_w, in_d, out_ready,
    input  busy, in_ready, out_valid, out_sum
  );

  modport slave (
    input  start, cfg_wprec, cfg_dprec, cfg_wsigned, cfg_dsigned,
    input  in_valid, in_w, in_d, out_ready,
    output busy, in_ready, out_valid, out_sum
  );
endinterface

// File: rtl/vvp_bitserial_acc.sv
// Bit-serial multi-precision dot product: one weight/data bit-plane pair per cycle,
// popcount of the AND, signed shift-accumulate into a wrapping accumulator.
module vvp_bitserial_acc #(
  parameter int unsigned N    = 64,
  parameter int unsigned PMAX = 8,
  parameter int unsigned ACCW = $clog2(N + 1) + 2 * PMAX + 1,
  parameter int unsigned PIPE = 1
) (
  input logic               clk,
  input logic               rst_n,
  vvp_bitserial_acc_if.slave bus
);
  localparam int unsigned CW = $clog2(PMAX + 1);
  localparam int unsigned PW = $clog2(N + 1);
  localparam int unsigned SW = CW + 1;
  localparam logic [CW-1:0] One = CW'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e          state_q;
  logic [CW-1:0]   wprec_q;
  logic [CW-1:0]   dprec_q;
  logic [CW-1:0]   i_q;
  logic [CW-1:0]   j_q;
  logic            wsigned_q;
  logic            dsigned_q;
  logic            busy_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic            term_vld_q;
  logic [ACCW-1:0] term_q;
  logic [ACCW-1:0] acc_q;
  logic [ACCW-1:0] out_sum_q;

  logic [PW-1:0]   pop;
  logic [SW-1:0]   shamt;
  logic            w_last;
  logic            d_last;
  logic            neg;
  logic            accept;
  logic            last_pair;
  logic [ACCW-1:0] mag;
  logic [ACCW-1:0] term;
  logic [ACCW-1:0] addend;
  logic [ACCW-1:0] acc_sum;

  // Zero precision means one plane; anything above PMAX saturates to PMAX.
  function automatic logic [CW-1:0] eff_prec(input logic [CW-1:0] p);
    if (p == '0) begin
      return One;
    end
    if (32'(p) > PMAX) begin
      return CW'(PMAX);
    end
    return p;
  endfunction

  always_comb begin
    pop = '0;
    for (int k = 0; k < int'(N); k++) begin
      pop = pop + PW'(bus.in_w[k] & bus.in_d[k]);
    end
    w_last    = (i_q == wprec_q - One);
    d_last    = (j_q == dprec_q - One);
    neg       = (wsigned_q & w_last) ^ (dsigned_q & d_last);
    shamt     = SW'(i_q) + SW'(j_q);
    mag       = ACCW'(pop) << shamt;
    term      = neg ? (ACCW'(0) - mag) : mag;
    accept    = in_ready_q & bus.in_valid;
    last_pair = w_last & d_last;
    // With the term register in place the accumulator lags the accepted pair by one cycle.
    if (PIPE != 0) begin
      addend = term_vld_q ? term_q : '0;
    end else begin
      addend = accept ? term : '0;
    end
    acc_sum = acc_q + addend;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      wprec_q     <= '0;
      dprec_q     <= '0;
      i_q         <= '0;
      j_q         <= '0;
      wsigned_q   <= 1'b0;
      dsigned_q   <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      term_vld_q  <= 1'b0;
      term_q      <= '0;
      acc_q       <= '0;
      out_sum_q   <= '0;
    end else begin
      term_vld_q <= accept;
      if (accept) begin
        term_q <= term;
      end
      acc_q <= acc_sum;

      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            wprec_q    <= eff_prec(bus.cfg_wprec);
            dprec_q    <= eff_prec(bus.cfg_dprec);
            wsigned_q  <= bus.cfg_wsigned;
            dsigned_q  <= bus.cfg_dsigned;
            acc_q      <= '0;
            i_q        <= '0;
            j_q        <= '0;
            term_vld_q <= 1'b0;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b1;
            state_q    <= StRun;
          end
        end

        StRun: begin
          if (accept) begin
            if (d_last) begin
              j_q <= '0;
              i_q <= w_last ? '0 : i_q + One;
            end else begin
              j_q <= j_q + One;
            end
            if (last_pair) begin
              in_ready_q <= 1'b0;
              if (PIPE != 0) begin
                state_q <= StDrain;
              end else begin
                out_sum_q   <= acc_sum;
                out_valid_q <= 1'b1;
                state_q     <= StDone;
              end
            end
          end
        end

        StDrain: begin
          out_sum_q   <= acc_sum;
          out_valid_q <= 1'b1;
          state_q     <= StDone;
        end

        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
endmodule

// File: tb/tb_vvp_bitserial_acc.sv
// Bench for the bit-serial dot-product accumulator: runs PIPE=1 and PIPE=0 instances side by side
// against a lane-level integer dot-product model and a transaction timeline.
module tb_vvp_bitserial_acc;
  localparam int unsigned N    = 64;
  localparam int unsigned PMAX = 8;
  localparam int unsigned ACCW = $clog2(N + 1) + 2 * PMAX + 1;
  localparam int unsigned CW   = $clog2(PMAX + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start;
  logic [CW-1:0] cfg_wprec;
  logic [CW-1:0] cfg_dprec;
  logic          cfg_wsigned;
  logic          cfg_dsigned;
  logic          in_valid;
  logic [N-1:0]  in_w;
  logic [N-1:0]  in_d;
  logic          out_ready;

  vvp_bitserial_acc_if #(.N(N), .PMAX(PMAX), .ACCW(ACCW)) bus1 ();
  vvp_bitserial_acc_if #(.N(N), .PMAX(PMAX), .ACCW(ACCW)) bus0 ();

  assign bus1.start = start;        assign bus0.start = start;
  assign bus1.cfg_wprec = cfg_wprec; assign bus0.cfg_wprec = cfg_wprec;
  assign bus1.cfg_dprec = cfg_dprec; assign bus0.cfg_dprec = cfg_dprec;
  assign bus1.cfg_wsigned = cfg_wsigned; assign bus0.cfg_wsigned = cfg_wsigned;
  assign bus1.cfg_dsigned = cfg_dsigned; assign bus0.cfg_dsigned = cfg_dsigned;
  assign bus1.in_valid = in_valid;  assign bus0.in_valid = in_valid;
  assign bus1.in_w = in_w;          assign bus0.in_w = in_w;
  assign bus1.in_d = in_d;          assign bus0.in_d = in_d;
  assign bus1.out_ready = out_ready; assign bus0.out_ready = out_ready;

  vvp_bitserial_acc #(.N(N), .PMAX(PMAX), .ACCW(ACCW), .PIPE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave)
  );
  vvp_bitserial_acc #(.N(N), .PMAX(PMAX), .ACCW(ACCW), .PIPE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave)
  );

  int checks;
  int errors;

  // Model: lane values, expected sum, and a transaction timeline per instance (index = PIPE).
  int              wv[N];
  int              dv[N];
  logic [ACCW-1:0] exp_sum;
  int              total;
  int              pairs;
  int              cyc;
  int              last_acc;
  bit              last_seen;
  bit              exp_run;
  int              st[2];
  bit              exp_valid[2];

  task automatic check(input string name, input logic [ACCW-1:0] act, input logic [ACCW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(input int p, input logic b, input logic ir, input logic ov,
                         input logic [ACCW-1:0] os);
    check($sformatf("busy_p%0d", p), ACCW'(b), ACCW'(st[p] != 0));
    check($sformatf("in_ready_p%0d", p), ACCW'(ir), ACCW'(exp_run));
    check($sformatf("out_valid_p%0d", p), ACCW'(ov), ACCW'(exp_valid[p]));
    if (exp_valid[p]) check($sformatf("out_sum_p%0d", p), os, exp_sum);
  endtask

  always @(negedge clk) begin
    cmp_dut(1, bus1.busy, bus1.in_ready, bus1.out_valid, bus1.out_sum);
    cmp_dut(0, bus0.busy, bus0.in_ready, bus0.out_valid, bus0.out_sum);
  end

  function automatic int eff(input int p);
    if (p == 0) return 1;
    if (p > int'(PMAX)) return int'(PMAX);
    return p;
  endfunction

  function automatic int rnd_val(input int p, input bit sg);
    int u;
    u = int'($urandom_range(0, (1 << p) - 1));
    return sg ? u - (1 << (p - 1)) : u;
  endfunction

  // Advance one clock and update the timeline from the inputs present at that edge.
  task automatic step();
    bit s;
    bit v;
    bit r;
    s = start;
    v = in_valid;
    r = out_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (rst_n) begin
      if (s && st[0] == 0 && st[1] == 0) begin
        st[0] = 1; st[1] = 1; exp_run = 1'b1; pairs = 0; last_seen = 1'b0;
      end else begin
        if (v && exp_run) begin
          pairs++;
          if (pairs == total) begin
            exp_run = 1'b0; last_seen = 1'b1; last_acc = cyc;
          end
        end
        for (int p = 0; p < 2; p++) if (exp_valid[p] && r) st[p] = 0;
      end
      for (int p = 0; p < 2; p++)
        exp_valid[p] = (st[p] == 1) && last_seen && (cyc >= last_acc + p);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy1"}, ACCW'(bus1.busy), '0);
    check({tag, "_busy0"}, ACCW'(bus0.busy), '0);
    check({tag, "_in_ready1"}, ACCW'(bus1.in_ready), '0);
    check({tag, "_in_ready0"}, ACCW'(bus0.in_ready), '0);
    check({tag, "_out_valid1"}, ACCW'(bus1.out_valid), '0);
    check({tag, "_out_valid0"}, ACCW'(bus0.out_valid), '0);
    check({tag, "_out_sum1"}, bus1.out_sum, '0);
    check({tag, "_out_sum0"}, bus0.out_sum, '0);
  endtask

  task automatic run_txn(input int wcfg, input int dcfg, input bit ws, input bit ds,
                         input bit gaps, input bit meddle, input int hold, input int abort_at,
                         input bit use_lit, input logic [ACCW-1:0] lit);
    int              wp;
    int              dp;
    int              idx;
    int              guard;
    int              pi;
    int              pj;
    bit              rdy;
    longint          s;
    logic [31:0]     t;
    logic [ACCW-1:0] got[2];
    wp = eff(wcfg);
    dp = eff(dcfg);
    total = wp * dp;
    s = 0;
    for (int k = 0; k < int'(N); k++) s += longint'(wv[k]) * longint'(dv[k]);
    exp_sum = s[ACCW-1:0];
    if (use_lit) check("model_ref", exp_sum, lit);
    got[0] = '0;
    got[1] = '0;

    cfg_wprec = CW'(wcfg); cfg_dprec = CW'(dcfg);
    cfg_wsigned = ws; cfg_dsigned = ds;
    out_ready = 1'b0; in_valid = 1'b0; start = 1'b1;
    step();
    start = 1'b0;

    idx = 0;
    guard = 0;
    while (idx < total && guard < 1000) begin
      pi = idx / dp;
      pj = idx % dp;
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int k = 0; k < int'(N); k++) begin
        t = wv[k]; in_w[k] = t[pi];
        t = dv[k]; in_d[k] = t[pj];
      end
      if (meddle) begin
        start = 1'($urandom_range(0, 1));
        cfg_wprec = CW'($urandom); cfg_dprec = CW'($urandom);
        cfg_wsigned = 1'($urandom); cfg_dsigned = 1'($urandom);
      end
      rdy = bus1.in_ready;
      step();
      guard++;
      if (in_valid && rdy) idx++;
      if (abort_at >= 0 && idx == abort_at) begin
        in_valid = 1'b0; start = 1'b0;
        rst_n = 1'b0;
        st[0] = 0; st[1] = 0; exp_run = 1'b0; last_seen = 1'b0;
        exp_valid[0] = 1'b0; exp_valid[1] = 1'b0;
        #1;
        check_reset_outputs("abort");
        step();
        rst_n = 1'b1;
        return;
      end
    end
    in_valid = 1'b0;
    start = 1'b0;
    check("run_pairs_accepted", ACCW'(idx), ACCW'(total));

    for (int c = 0; c < hold; c++) step();
    out_ready = 1'b1;
    // Start together with the output handshake must be ignored.
    if (meddle && exp_valid[0] && exp_valid[1]) start = 1'b1;
    guard = 0;
    while ((st[0] != 0 || st[1] != 0) && guard < 50) begin
      if (exp_valid[0]) got[0] = bus0.out_sum;
      if (exp_valid[1]) got[1] = bus1.out_sum;
      step();
      start = 1'b0;
      guard++;
    end
    out_ready = 1'b0;
    check("result_handshake_done", ACCW'(st[0] + st[1]), '0);
    if (use_lit) begin
      check("lit_sum_p0", got[0], lit);
      check("lit_sum_p1", got[1], lit);
    end
  endtask

  task automatic fill(input int w, input int d);
    for (int k = 0; k < int'(N); k++) begin
      wv[k] = w;
      dv[k] = d;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc;
    int dc;
    bit ws;
    bit ds;
    checks = 0; errors = 0; cyc = 0; total = 1; pairs = 0;
    last_acc = 0; last_seen = 1'b0; exp_run = 1'b0; exp_sum = '0;
    st[0] = 0; st[1] = 0; exp_valid[0] = 1'b0; exp_valid[1] = 1'b0;
    start = 1'b0; cfg_wprec = '0; cfg_dprec = '0; cfg_wsigned = 1'b0; cfg_dsigned = 1'b0;
    in_valid = 1'b0; in_w = '0; in_d = '0; out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    step();

    fill(1, 1);     run_txn(1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1, 1'b1, ACCW'(64));
    fill(-1, 1);    run_txn(2, 2, 1'b1, 1'b1, 1'b0, 1'b0, 0, -1, 1'b1, ACCW'(-64));
    fill(255, 255); run_txn(8, 8, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1, 1'b1, ACCW'(4161600));
    fill(-1, 1);    run_txn(2, 2, 1'b1, 1'b1, 1'b1, 1'b0, 5, -1, 1'b1, ACCW'(-64));
    fill(1, 5);     run_txn(0, 3, 1'b0, 1'b0, 1'b1, 1'b1, 3, -1, 1'b1, ACCW'(320));
    fill(-1, 1);    run_txn(2, 2, 1'b1, 1'b1, 1'b0, 1'b0, 0, 2, 1'b0, '0);
    fill(-1, 1);    run_txn(2, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1, -1, 1'b1, ACCW'(-64));

    for (int n = 0; n < 20; n++) begin
      wc = int'($urandom_range(0, (1 << CW) - 1));
      dc = int'($urandom_range(0, (1 << CW) - 1));
      ws = 1'($urandom);
      ds = 1'($urandom);
      for (int k = 0; k < int'(N); k++) begin
        wv[k] = rnd_val(eff(wc), ws);
        dv[k] = rnd_val(eff(dc), ds);
      end
      run_txn(wc, dc, ws, ds, 1'($urandom), 1'($urandom), int'($urandom_range(0, 4)), -1,
              1'b0, '0);
    end

    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
